// File: rtl/rf_pkg.sv
// Shared encodings for the scoreboarded register file: write-back source select and read FSM states.
package rf_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_CSR  = 2'd2,
    WB_NONE = 2'd3
  } wb_sel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit tracker for pending register writes plus a combinational hazard query over NRP read ports.
// Same-cycle reserve and write-back to one register leaves the bit set; register 0 is never busy.
module rf_scoreboard #(
  parameter int NREGS = 32,
  parameter int NRP   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                rsv_en_i,
  input  logic [AW-1:0]       rsv_addr_i,
  input  logic                wb_en_i,
  input  logic [AW-1:0]       wb_addr_i,
  input  logic [NRP-1:0]      q_en_i,
  input  logic [NRP*AW-1:0]   q_addr_i,
  output logic                hazard_o,
  output logic [NREGS-1:0]    busy_o
);

  logic [NREGS-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (wb_en_i && wb_addr_i != '0) busy_d[wb_addr_i] = 1'b0;
    // Set after clear so a same-cycle reservation wins.
    if (rsv_en_i && rsv_addr_i != '0) busy_d[rsv_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    hazard_o = 1'b0;
    for (int p = 0; p < NRP; p++) begin
      if (q_en_i[p] && busy_q[q_addr_i[p*AW +: AW]] &&
          !(wb_en_i && wb_addr_i == q_addr_i[p*AW +: AW])) begin
        hazard_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with scoreboard-stalled multi-port reads: data one cycle after a hazard-free accept,
// otherwise rd_ready_o drops while waiting on the pending write; write-back bypasses into the capture.
module regfile_sb import rf_pkg::*; #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRP   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rd_req_i,
  output logic                 rd_ready_o,
  input  logic [NRP-1:0]       rs_en_i,
  input  logic [NRP*AW-1:0]    rs_addr_i,
  output logic [NRP*XLEN-1:0]  rs_val_o,
  output logic                 rd_valid_o,
  input  logic                 wb_en_i,
  input  logic [AW-1:0]        wb_addr_i,
  input  logic [1:0]           wb_sel_i,
  input  logic [XLEN-1:0]      alu_result_i,
  input  logic [XLEN-1:0]      load_result_i,
  input  logic [XLEN-1:0]      csr_val_i,
  input  logic                 rsv_en_i,
  input  logic [AW-1:0]        rsv_addr_i,
  output logic [NREGS-1:0]     busy_o
);

  logic [XLEN-1:0]     regs_q [NREGS];
  logic [XLEN-1:0]     regs_d [NREGS];
  rf_state_e           state_q, state_d;
  logic [NRP-1:0]      lat_en_q, lat_en_d;
  logic [NRP*AW-1:0]   lat_addr_q, lat_addr_d;
  logic [NRP*XLEN-1:0] rs_val_q, rs_val_d;
  logic                rd_valid_q, rd_valid_d;

  logic [XLEN-1:0]     wb_data;
  logic                wb_write;
  logic                hazard;
  logic                capture;
  logic [NRP-1:0]      q_en;
  logic [NRP*AW-1:0]   q_addr;

  always_comb begin
    case (wb_sel_e'(wb_sel_i))
      WB_ALU:  wb_data = alu_result_i;
      WB_LOAD: wb_data = load_result_i;
      WB_CSR:  wb_data = csr_val_i;
      default: wb_data = '0;
    endcase
  end

  assign wb_write = wb_en_i && (wb_sel_i != WB_NONE) && (wb_addr_i != '0);

  always_comb begin
    regs_d = regs_q;
    if (wb_write) regs_d[wb_addr_i] = wb_data;
    regs_d[0] = '0;
  end

  // While waiting, the hazard is re-evaluated on the addresses latched at accept.
  assign q_en   = (state_q == ST_WAIT) ? lat_en_q   : rs_en_i;
  assign q_addr = (state_q == ST_WAIT) ? lat_addr_q : rs_addr_i;

  rf_scoreboard #(.NREGS(NREGS), .NRP(NRP)) u_sb (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rsv_en_i   (rsv_en_i),
    .rsv_addr_i (rsv_addr_i),
    .wb_en_i    (wb_en_i),
    .wb_addr_i  (wb_addr_i),
    .q_en_i     (q_en),
    .q_addr_i   (q_addr),
    .hazard_o   (hazard),
    .busy_o     (busy_o)
  );

  always_comb begin
    state_d    = state_q;
    lat_en_d   = lat_en_q;
    lat_addr_d = lat_addr_q;
    capture    = 1'b0;
    rd_ready_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rd_ready_o = 1'b1;
        if (rd_req_i) begin
          if (hazard) begin
            lat_en_d   = rs_en_i;
            lat_addr_d = rs_addr_i;
            state_d    = ST_WAIT;
          end else begin
            capture = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (!hazard) begin
          capture = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rs_val_d   = rs_val_q;
    rd_valid_d = capture;
    if (capture) begin
      for (int p = 0; p < NRP; p++) begin
        if (!q_en[p] || q_addr[p*AW +: AW] == '0)
          rs_val_d[p*XLEN +: XLEN] = '0;
        else if (wb_write && q_addr[p*AW +: AW] == wb_addr_i)
          rs_val_d[p*XLEN +: XLEN] = wb_data;
        else
          rs_val_d[p*XLEN +: XLEN] = regs_q[q_addr[p*AW +: AW]];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      state_q    <= ST_IDLE;
      lat_en_q   <= '0;
      lat_addr_q <= '0;
      rs_val_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      state_q    <= state_d;
      lat_en_q   <= lat_en_d;
      lat_addr_q <= lat_addr_d;
      rs_val_q   <= rs_val_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rs_val_o   = rs_val_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboarded bench for regfile_sb: default config (32 regs, 2 ports) and a 16-reg, 3-port instance.
module tb_regfile_sb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Instance A: XLEN=32, NREGS=32, NRP=2
  logic        a_rd_req = 0, a_rd_ready, a_rd_valid;
  logic [1:0]  a_rs_en = 0;
  logic [9:0]  a_rs_addr = 0;
  logic [63:0] a_rs_val;
  logic        a_wb_en = 0, a_rsv_en = 0;
  logic [4:0]  a_wb_addr = 0, a_rsv_addr = 0;
  logic [1:0]  a_wb_sel = 0;
  logic [31:0] a_alu = 0, a_load = 0, a_csr = 0;
  logic [31:0] a_busy;
  logic [63:0] a_exp_q[$];

  regfile_sb u_a (
    .clk_i(clk), .rst_i(rst), .rd_req_i(a_rd_req), .rd_ready_o(a_rd_ready),
    .rs_en_i(a_rs_en), .rs_addr_i(a_rs_addr), .rs_val_o(a_rs_val), .rd_valid_o(a_rd_valid),
    .wb_en_i(a_wb_en), .wb_addr_i(a_wb_addr), .wb_sel_i(a_wb_sel),
    .alu_result_i(a_alu), .load_result_i(a_load), .csr_val_i(a_csr),
    .rsv_en_i(a_rsv_en), .rsv_addr_i(a_rsv_addr), .busy_o(a_busy)
  );

  // Instance B: XLEN=32, NREGS=16, NRP=3
  logic        b_rd_req = 0, b_rd_ready, b_rd_valid;
  logic [2:0]  b_rs_en = 0;
  logic [11:0] b_rs_addr = 0;
  logic [95:0] b_rs_val;
  logic        b_wb_en = 0, b_rsv_en = 0;
  logic [3:0]  b_wb_addr = 0, b_rsv_addr = 0;
  logic [1:0]  b_wb_sel = 0;
  logic [31:0] b_alu = 0, b_load = 0, b_csr = 0;
  logic [15:0] b_busy;
  logic [95:0] b_exp_q[$];

  regfile_sb #(.XLEN(32), .NREGS(16), .NRP(3)) u_b (
    .clk_i(clk), .rst_i(rst), .rd_req_i(b_rd_req), .rd_ready_o(b_rd_ready),
    .rs_en_i(b_rs_en), .rs_addr_i(b_rs_addr), .rs_val_o(b_rs_val), .rd_valid_o(b_rd_valid),
    .wb_en_i(b_wb_en), .wb_addr_i(b_wb_addr), .wb_sel_i(b_wb_sel),
    .alu_result_i(b_alu), .load_result_i(b_load), .csr_val_i(b_csr),
    .rsv_en_i(b_rsv_en), .rsv_addr_i(b_rsv_addr), .busy_o(b_busy)
  );

  // Every rd_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && a_rd_valid) begin
      tests++;
      if (a_exp_q.size() == 0) begin
        fails++;
        $display("FAIL a_valid_unexpected: got rd_valid=1 data=%h, want no pulse", a_rs_val);
      end else begin
        logic [63:0] e;
        e = a_exp_q.pop_front();
        if (a_rs_val !== e) begin
          fails++;
          $display("FAIL a_rs_val: got %h want %h", a_rs_val, e);
        end
      end
    end
    if (!rst && b_rd_valid) begin
      tests++;
      if (b_exp_q.size() == 0) begin
        fails++;
        $display("FAIL b_valid_unexpected: got rd_valid=1 data=%h, want no pulse", b_rs_val);
      end else begin
        logic [95:0] e;
        e = b_exp_q.pop_front();
        if (b_rs_val !== e) begin
          fails++;
          $display("FAIL b_rs_val: got %h want %h", b_rs_val, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((a_exp_q.size() != 0 || b_exp_q.size() != 0) && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    tests++;
    if (a_exp_q.size() != 0 || b_exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_timeout: got %0d/%0d results outstanding, want 0",
               name, a_exp_q.size(), b_exp_q.size());
      a_exp_q.delete();
      b_exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tests += 4;
    if (a_rd_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", a_rd_ready); end
    if (a_rd_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", a_rd_valid); end
    if (a_busy !== 32'h0) begin fails++; $display("FAIL reset_busy: got %h want 0", a_busy); end
    if (a_rs_val !== 64'h0) begin fails++; $display("FAIL reset_rs_val: got %h want 0", a_rs_val); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_read();
    a_wb_en = 1; a_wb_addr = 5; a_wb_sel = 2'd0; a_alu = 32'hDEADBEEF;
    tick();
    a_wb_en = 0;
    a_rd_req = 1; a_rs_en = 2'b11; a_rs_addr = {5'd0, 5'd5};
    a_exp_q.push_back({32'h0, 32'hDEADBEEF});
    tick();
    a_rd_req = 0;
    drain("basic");
    tick(); tick();
    tests++;
    if (a_rs_val !== {32'h0, 32'hDEADBEEF}) begin
      fails++; $display("FAIL basic_hold: got %h want %h", a_rs_val, {32'h0, 32'hDEADBEEF});
    end
  endtask

  task automatic test_stall_read();
    a_rsv_en = 1; a_rsv_addr = 7;
    tick();
    a_rsv_en = 0;
    tests++;
    if (a_busy[7] !== 1'b1) begin fails++; $display("FAIL stall_busy_set: got %b want 1", a_busy[7]); end
    // Port 1 is disabled but points at x5 (holding DEADBEEF): its slice must be zero.
    a_rd_req = 1; a_rs_en = 2'b01; a_rs_addr = {5'd5, 5'd7};
    a_exp_q.push_back({32'h0, 32'h00001234});
    tick();
    a_rd_req = 0;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (a_rd_ready !== 1'b0) begin fails++; $display("FAIL stall_ready_wait%0d: got %b want 0", i, a_rd_ready); end
      tick();
    end
    a_wb_en = 1; a_wb_addr = 7; a_wb_sel = 2'd1; a_load = 32'h1234;
    tick();
    a_wb_en = 0;
    drain("stall");
    tests += 2;
    if (a_busy[7] !== 1'b0) begin fails++; $display("FAIL stall_busy_clear: got %b want 0", a_busy[7]); end
    if (a_rd_ready !== 1'b1) begin fails++; $display("FAIL stall_ready_idle: got %b want 1", a_rd_ready); end
  endtask

  task automatic test_reserve_wins();
    a_rsv_en = 1; a_rsv_addr = 9;
    a_wb_en = 1; a_wb_addr = 9; a_wb_sel = 2'd0; a_alu = 32'h55;
    tick();
    a_rsv_en = 0; a_wb_en = 0;
    tests++;
    if (a_busy[9] !== 1'b1) begin fails++; $display("FAIL rsvwin_busy: got %b want 1", a_busy[9]); end
    a_rd_req = 1; a_rs_en = 2'b01; a_rs_addr = {5'd0, 5'd9};
    a_exp_q.push_back({32'h0, 32'h55});
    tick();
    a_rd_req = 0;
    tests++;
    if (a_rd_ready !== 1'b0) begin fails++; $display("FAIL rsvwin_stall: got ready=%b want 0", a_rd_ready); end
    // Release with a no-write write-back: the stored 0x55 must come from the array.
    a_wb_en = 1; a_wb_addr = 9; a_wb_sel = 2'd3; a_alu = 32'hFFFF_FFFF;
    tick();
    a_wb_en = 0;
    drain("rsvwin");
  endtask

  task automatic test_bypass_x0();
    a_rd_req = 1; a_rs_en = 2'b11; a_rs_addr = {5'd0, 5'd3};
    a_wb_en = 1; a_wb_addr = 3; a_wb_sel = 2'd2; a_csr = 32'hA5A5;
    a_exp_q.push_back({32'h0, 32'h0000A5A5});
    tick();
    a_rd_req = 0; a_wb_en = 0;
    drain("bypass");
    a_wb_en = 1; a_wb_addr = 0; a_wb_sel = 2'd0; a_alu = 32'hFFFF_FFFF;
    a_rsv_en = 1; a_rsv_addr = 0;
    tick();
    a_wb_en = 0; a_rsv_en = 0;
    tests++;
    if (a_busy[0] !== 1'b0) begin fails++; $display("FAIL x0_busy: got %b want 0", a_busy[0]); end
    a_rd_req = 1; a_rs_en = 2'b11; a_rs_addr = {5'd3, 5'd0};
    a_exp_q.push_back({32'h0000A5A5, 32'h0});
    tick();
    a_rd_req = 0;
    drain("x0");
  endtask

  task automatic test_reset_mid_wait();
    a_rsv_en = 1; a_rsv_addr = 12;
    tick();
    a_rsv_en = 0;
    a_rd_req = 1; a_rs_en = 2'b01; a_rs_addr = {5'd0, 5'd12};
    tick();
    a_rd_req = 0;
    tests++;
    if (a_rd_ready !== 1'b0) begin fails++; $display("FAIL rstwait_in_wait: got %b want 0", a_rd_ready); end
    #2 rst = 1'b1;
    #1;
    tests += 3;
    if (a_rd_ready !== 1'b1) begin fails++; $display("FAIL rstwait_ready: got %b want 1", a_rd_ready); end
    if (a_busy !== 32'h0) begin fails++; $display("FAIL rstwait_busy: got %h want 0", a_busy); end
    if (a_rd_valid !== 1'b0) begin fails++; $display("FAIL rstwait_valid: got %b want 0", a_rd_valid); end
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    a_rd_req = 1; a_rs_en = 2'b11; a_rs_addr = {5'd3, 5'd5};
    a_exp_q.push_back(64'h0);
    tick();
    a_rd_req = 0;
    drain("rstwait");
  endtask

  task automatic test_b_basic();
    b_wb_en = 1; b_wb_addr = 5; b_wb_sel = 2'd0; b_alu = 32'hDEADBEEF;
    tick();
    b_wb_en = 0;
    b_rd_req = 1; b_rs_en = 3'b111; b_rs_addr = {4'd5, 4'd0, 4'd5};
    b_exp_q.push_back({32'hDEADBEEF, 32'h0, 32'hDEADBEEF});
    tick();
    b_rd_req = 0;
    drain("b_basic");
  endtask

  task automatic test_b_stall();
    b_rsv_en = 1; b_rsv_addr = 7;
    tick();
    b_rsv_en = 0;
    b_rd_req = 1; b_rs_en = 3'b011; b_rs_addr = {4'd5, 4'd5, 4'd7};
    b_exp_q.push_back({32'h0, 32'hDEADBEEF, 32'h00001234});
    tick();
    b_rd_req = 0;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (b_rd_ready !== 1'b0) begin fails++; $display("FAIL b_stall_ready_wait%0d: got %b want 0", i, b_rd_ready); end
      tick();
    end
    b_wb_en = 1; b_wb_addr = 7; b_wb_sel = 2'd1; b_load = 32'h1234;
    tick();
    b_wb_en = 0;
    drain("b_stall");
    tests++;
    if (b_busy !== 16'h0) begin fails++; $display("FAIL b_stall_busy: got %h want 0", b_busy); end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_stall_read();
    test_reserve_wins();
    test_bypass_x0();
    test_reset_mid_wait();
    test_b_basic();
    test_b_stall();
    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
